// File: rtl/quad_step_decoder.sv
// Quadrature phase decoder: synchronises and debounces A/B, then emits one-cycle
// INC/DEC step commands for an up/down counter and flags illegal double transitions.
module quad_step_decoder #(
    parameter int DB_CYCLES  = 4,
    parameter bit DIR_INVERT = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       a_i,
    input  logic       b_i,
    output logic [1:0] control_o,
    output logic       err_o,
    output logic [1:0] ab_o
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam int WW = $clog2(DB_CYCLES + 3);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DB_CYCLES - 1);
    localparam logic [WW-1:0] WARM_LOAD = WW'(DB_CYCLES + 2);
    localparam logic [WW-1:0] WARM_ONE  = WW'(1);
    localparam logic [1:0] CODE_HOLD = 2'b00;
    localparam logic [1:0] CODE_INC  = DIR_INVERT ? 2'b10 : 2'b01;
    localparam logic [1:0] CODE_DEC  = DIR_INVERT ? 2'b01 : 2'b10;

    // Index 1 carries phase A, index 0 phase B, so vectors read as {A,B}.
    logic [1:0]    sync1_r;
    logic [1:0]    sync2_r;
    logic [1:0]    filt_r;
    logic [1:0]    filt_nxt_s;
    logic [CW-1:0] cnt_r     [2];
    logic [CW-1:0] cnt_nxt_s [2];
    logic [1:0]    prev_r;
    logic [WW-1:0] warm_r;
    logic [1:0]    control_r;
    logic          err_r;
    logic [1:0]    delta_s;
    logic [1:0]    control_nxt_s;
    logic          err_nxt_s;

    // Map Gray-coded {A,B} onto a linear position 0..3 along the forward sequence.
    function automatic logic [1:0] gray_pos(input logic [1:0] ab);
        return {ab[1], ab[1] ^ ab[0]};
    endfunction

    // Per-phase debounce: filtered value moves only after DB_CYCLES stable disagreements.
    always_comb begin
        filt_nxt_s = filt_r;
        for (int i = 0; i < 2; i++) begin
            cnt_nxt_s[i] = {CW{1'b0}};
            if (sync2_r[i] == filt_r[i]) begin
                cnt_nxt_s[i] = {CW{1'b0}};
            end else if (cnt_r[i] == CNT_LAST) begin
                filt_nxt_s[i] = sync2_r[i];
                cnt_nxt_s[i]  = {CW{1'b0}};
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CW'(1);
            end
        end
    end

    // Step decode from the positional difference between previous and current phases.
    always_comb begin
        control_nxt_s = CODE_HOLD;
        err_nxt_s     = 1'b0;
        delta_s       = gray_pos(filt_r) - gray_pos(prev_r);
        case (delta_s)
            2'd0: begin
                control_nxt_s = CODE_HOLD;
                err_nxt_s     = 1'b0;
            end
            2'd1: begin
                control_nxt_s = CODE_INC;
                err_nxt_s     = 1'b0;
            end
            2'd3: begin
                control_nxt_s = CODE_DEC;
                err_nxt_s     = 1'b0;
            end
            2'd2: begin
                control_nxt_s = CODE_HOLD;
                err_nxt_s     = 1'b1;
            end
            default: begin
                control_nxt_s = CODE_HOLD;
                err_nxt_s     = 1'b0;
            end
        endcase
    end

    // Synchroniser, filter state, warm-up and registered step outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_r   <= 2'b00;
            sync2_r   <= 2'b00;
            filt_r    <= 2'b00;
            cnt_r[0]  <= {CW{1'b0}};
            cnt_r[1]  <= {CW{1'b0}};
            prev_r    <= 2'b00;
            warm_r    <= WARM_LOAD;
            control_r <= 2'b00;
            err_r     <= 1'b0;
        end else begin
            sync1_r  <= {a_i, b_i};
            sync2_r  <= sync1_r;
            filt_r   <= filt_nxt_s;
            cnt_r[0] <= cnt_nxt_s[0];
            cnt_r[1] <= cnt_nxt_s[1];
            if (warm_r != {WW{1'b0}}) begin
                warm_r    <= warm_r - WARM_ONE;
                control_r <= 2'b00;
                err_r     <= 1'b0;
                // Take the value being written so a level that settles on the last
                // warm-up edge is not later seen as a transition.
                if (warm_r == WARM_ONE) begin
                    prev_r <= filt_nxt_s;
                end else begin
                    prev_r <= filt_r;
                end
            end else begin
                warm_r    <= warm_r;
                prev_r    <= filt_r;
                control_r <= control_nxt_s;
                err_r     <= err_nxt_s;
            end
        end
    end

    assign control_o = control_r;
    assign err_o     = err_r;
    assign ab_o      = filt_r;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Scoreboard bench for quad_step_decoder: a normal and a direction-inverted instance
// share the same pins; expected pulses are queued at drive time and matched by cycle.
module tb_quad_step_decoder;

    localparam logic [1:0] INC = 2'b01;
    localparam logic [1:0] DEC = 2'b10;
    localparam logic [1:0] HLD = 2'b00;
    // Pin change driven at a falling edge appears on control_o this many cycles later.
    localparam int unsigned LAT = 7;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       a_i;
    logic       b_i;
    logic [1:0] ctrl0, ctrl1;
    logic       err0, err1;
    logic [1:0] ab0, ab1;

    int unsigned cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    typedef struct {
        int unsigned cyc;
        logic [1:0]  c0;
        logic [1:0]  c1;
        logic        err;
    } exp_t;
    exp_t sb_q[$];

    quad_step_decoder #(.DB_CYCLES(4), .DIR_INVERT(1'b0)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .a_i(a_i), .b_i(b_i),
        .control_o(ctrl0), .err_o(err0), .ab_o(ab0)
    );

    quad_step_decoder #(.DB_CYCLES(4), .DIR_INVERT(1'b1)) dut_inv (
        .clk_i(clk_i), .rst_ni(rst_ni), .a_i(a_i), .b_i(b_i),
        .control_o(ctrl1), .err_o(err1), .ab_o(ab1)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Output monitor: match queued pulses by cycle, flag any unexpected activity.
    always @(negedge clk_i) begin
        exp_t e;
        check_val("ctrl_never_11", {6'd0, ctrl0 == 2'b11, ctrl1 == 2'b11}, 8'd0);
        if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
            e = sb_q.pop_front();
            check_val("ctrl_norm", {6'd0, ctrl0}, {6'd0, e.c0});
            check_val("ctrl_inv",  {6'd0, ctrl1}, {6'd0, e.c1});
            check_val("err_norm",  {7'd0, err0},  {7'd0, e.err});
            check_val("err_inv",   {7'd0, err1},  {7'd0, e.err});
        end else if (ctrl0 != 2'b00 || ctrl1 != 2'b00 || err0 || err1) begin
            check_val("spurious", {2'd0, ctrl0, ctrl1, err0, err1}, 8'd0);
        end
    end

    task automatic push_exp(input logic [1:0] c0, input logic [1:0] c1, input logic err);
        exp_t e;
        e.cyc = cyc + LAT;
        e.c0  = c0;
        e.c1  = c1;
        e.err = err;
        sb_q.push_back(e);
    endtask

    // Drive a new pin pair, queue its expected decode, let it settle, check ab_o.
    task automatic step(input logic a, input logic b, input logic [1:0] c0, input logic err);
        logic [1:0] c1;
        c1 = (c0 == INC) ? DEC : ((c0 == DEC) ? INC : HLD);
        @(negedge clk_i);
        a_i = a;
        b_i = b;
        push_exp(c0, c1, err);
        repeat (19) @(negedge clk_i);
        check_val("ab_norm", {6'd0, ab0}, {6'd0, a, b});
        check_val("ab_inv",  {6'd0, ab1}, {6'd0, a, b});
    endtask

    initial begin
        int unsigned rel;
        rst_ni = 1'b0;
        a_i = 1'b0;
        b_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check_val("rst_ctrl", {4'd0, ctrl0, ctrl1}, 8'd0);
        check_val("rst_err",  {6'd0, err0, err1}, 8'd0);
        check_val("rst_ab",   {4'd0, ab0, ab1}, 8'd0);
        rst_ni = 1'b1;
        repeat (12) @(negedge clk_i);

        // Forward and reverse full cycles
        step(1'b0, 1'b1, INC, 1'b0);
        step(1'b1, 1'b1, INC, 1'b0);
        step(1'b1, 1'b0, INC, 1'b0);
        step(1'b0, 1'b0, INC, 1'b0);
        step(1'b1, 1'b0, DEC, 1'b0);
        step(1'b1, 1'b1, DEC, 1'b0);
        step(1'b0, 1'b1, DEC, 1'b0);
        step(1'b0, 1'b0, DEC, 1'b0);

        // Glitches on A from rest at 01: 3 cycles is filtered, 4 cycles passes both edges
        step(1'b0, 1'b1, INC, 1'b0);
        @(negedge clk_i);
        a_i = 1'b1;
        repeat (3) @(negedge clk_i);
        a_i = 1'b0;
        repeat (20) @(negedge clk_i);
        check_val("glitch3_ab", {6'd0, ab0}, 8'h01);
        a_i = 1'b1;
        push_exp(INC, DEC, 1'b0);
        repeat (4) @(negedge clk_i);
        a_i = 1'b0;
        push_exp(DEC, INC, 1'b0);
        repeat (20) @(negedge clk_i);
        check_val("glitch4_ab", {6'd0, ab0}, 8'h01);
        step(1'b0, 1'b0, DEC, 1'b0);

        // Illegal double transition, then recovery
        step(1'b1, 1'b1, HLD, 1'b1);
        step(1'b1, 1'b0, INC, 1'b0);
        step(1'b1, 1'b1, DEC, 1'b0);

        // Reset with pins resting at 11
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check_val("midrst_ctrl", {4'd0, ctrl0, ctrl1}, 8'd0);
        check_val("midrst_err",  {6'd0, err0, err1}, 8'd0);
        check_val("midrst_ab",   {4'd0, ab0, ab1}, 8'd0);
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        rel = cyc;
        repeat (5) @(negedge clk_i);
        check_val("warm_ab_early", {4'd0, ab0, ab1}, 8'h00);
        @(negedge clk_i);
        check_val("warm_cycle", cyc - rel, 8'd6);
        check_val("warm_ab", {4'd0, ab0, ab1}, 8'h0F);
        repeat (20) @(negedge clk_i);
        check_val("sb_empty", sb_q.size(), 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/quad_step_decoder.md
Name: quad_step_decoder

Overview:
Decodes a two-phase quadrature input (rotary encoder or jog wheel) into single-cycle step commands on the 2-bit INC/DEC control protocol used by the project's up/down counter. It is the command-producing end of that interface, and its control_o connects directly to a counter's control_i. Raw pins are asynchronous, so the block synchronises, debounces and sequence-checks them before issuing steps. Illegal transitions are flagged, not counted.

Parameters:
DB_CYCLES, 4, number of consecutive cycles a synchronised input must differ from its filtered value before the filtered value updates; legal range 1..255.
DIR_INVERT, 0, when 1, INC and DEC codes are swapped at the output.

Ports:
clk_i  input  1  system clock, rising edge
rst_ni  input  1  asynchronous active-low reset
a_i  input  1  quadrature phase A, asynchronous to clk_i
b_i  input  1  quadrature phase B, asynchronous to clk_i
control_o  output  2  step command: 2'b00 hold, 2'b01 INC, 2'b10 DEC; 2'b11 never driven
err_o  output  1  one-cycle pulse on an illegal transition (both filtered phases change in the same cycle)
ab_o  output  2  current filtered phases {A,B}

Behaviour:
- Reset, asynchronous on rst_ni low: all flops clear; control_o=00, err_o=0, ab_o=00, debounce counters=0, warm-up counter loaded.
- Synchroniser: 2 flops per phase, reset value 0. Stage 1 samples the pin at edge k. Stage 2 is valid after edge k+1.
- Debounce, per phase, counter width ceil(log2(DB_CYCLES+1)):
  - sync==filt: counter clears to 0.
  - sync!=filt and counter==DB_CYCLES-1: filt<=sync and counter<=0.
  - sync!=filt otherwise: counter increments.
  - Result: a clean pin edge first sampled at edge k updates filt at edge k+1+DB_CYCLES.
  - A pulse held for fewer than DB_CYCLES synchronised cycles never reaches filt.
- Step decode, registered:
  - prev<=filt every cycle. Compare {A,B} prev against filt.
  - Forward sequence is 00->01->11->10->00. A forward step drives control_o=01 (INC); a reverse step drives 10 (DEC). DIR_INVERT swaps the two codes.
  - No change: control_o=00.
  - Both bits changed (00<->11, 01<->10): control_o=00 and err_o=1 for one cycle. prev still adopts filt, so decoding resynchronises.
- Latency: a clean pin edge first sampled at edge k produces control_o at edge k+2+DB_CYCLES. Every pulse lasts exactly one cycle.
- Step spacing: consecutive steps need at least DB_CYCLES cycles between filtered updates. Faster pin activity is filtered out, never miscounted as a double step.
- Warm-up:
  - For DB_CYCLES+2 cycles after reset release, control_o=00 and err_o=0 are forced, while the filters still track.
  - On the last warm-up cycle, prev<=filt.
  - Purpose: non-zero resting pin levels at reset (e.g. 11) emit no spurious step or error.
- Reset mid-operation: outputs clear immediately (asynchronous); in-flight debounce and step state is discarded.
- ab_o=filt, available the same cycle filt updates.

Test Plan:
- DB_CYCLES=4, DIR_INVERT=0, after warm-up, pins step 00->01->11->10->00 with 20 cycles per step -> exactly four control_o=01 pulses, each one cycle wide, each 6 cycles after the pin edge is first sampled; err_o stays 0.
- Same setup, reverse sequence 00->10->11->01->00 -> four control_o=10 pulses; feeding them to the counter moves count_o 0->255 (W=8) on the first pulse, proving DEC wrap.
- a_i glitch high for 3 cycles with DB_CYCLES=4 -> no filt change, control_o stays 00. The same glitch held for 4 cycles -> one INC pulse.
- a_i and b_i change 00->11 on the same edge -> err_o=1 for one cycle, control_o=00, ab_o=11. A following 11->10 step then yields one INC.
- Hold pins at 11, pulse rst_ni low for 3 cycles mid-sequence -> outputs 00 during reset; after release no control_o or err_o pulse through warm-up; ab_o=11 by cycle DB_CYCLES+2.
- DIR_INVERT=1, forward sequence -> four DEC (10) pulses; control_o never equals 11 in any test.
